// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (Diff = A - B - Bin), LSB first, one full-subtractor cell.
// Optional signed-overflow output enabled by defining SERSUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERSUB_OVF_EN
    ,
    output logic             Ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-2:0] r_q, r_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             d_bit;
    logic [WIDTH-1:0] r_ext;
`ifdef SERSUB_OVF_EN
    logic             am_q, am_d, bm_q, bm_d;
    logic             ovf_q, ovf_d;
`endif

    function automatic logic fs_diff(input logic a, input logic b, input logic bi);
        return a ^ b ^ bi;
    endfunction

    function automatic logic fs_borrow(input logic a, input logic b, input logic bi);
        return (~a & b) | (~(a ^ b) & bi);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERSUB_OVF_EN
        am_d    = am_q;
        bm_d    = bm_q;
        ovf_d   = ovf_q;
`endif
        d_bit   = fs_diff(a_q[0], b_q[0], brw_q);
        // New bit enters at the top; after the last shift r_ext is the whole result
        r_ext   = {d_bit, r_q};
        Busy    = (state_q == S_SHIFT);
        Done    = (state_q == S_DONE);

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    brw_d   = Bin;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
`ifdef SERSUB_OVF_EN
                    am_d    = A[WIDTH-1];
                    bm_d    = B[WIDTH-1];
`endif
                end
            end
            S_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = r_ext[WIDTH-1:1];
                brw_d = fs_borrow(a_q[0], b_q[0], brw_q);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d  = r_ext;
                    bout_d  = brw_d;
                    cnt_d   = '0;
                    state_d = S_DONE;
`ifdef SERSUB_OVF_EN
                    ovf_d   = (am_q != bm_q) & (d_bit != am_q);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERSUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Datapath registers are always reloaded on accept, so they need no reset
    always_ff @(posedge Clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        r_q   <= r_d;
        brw_q <= brw_d;
`ifdef SERSUB_OVF_EN
        am_q  <= am_d;
        bm_q  <= bm_d;
`endif
    end

    assign Diff = diff_q;
    assign Bout = bout_q;
`ifdef SERSUB_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule
